// File: rtl/mc_cpu_core_if.sv
// Instruction-memory fetch port and external ALU port of the multi-cycle core.
// The core side is the master; memory and ALU sit on the slave side.
interface mc_cpu_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [23:0]       imem_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_f;
    logic              alu_c;
    logic              alu_z;
    logic              alu_n;
    logic              alu_ov;

    modport master (
        output imem_addr, imem_req, alu_a, alu_b, alu_op,
        input  imem_ack, imem_data, alu_f, alu_c, alu_z, alu_n, alu_ov
    );

    modport slave (
        input  imem_addr, imem_req, alu_a, alu_b, alu_op,
        output imem_ack, imem_data, alu_f, alu_c, alu_z, alu_n, alu_ov
    );
endinterface

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH -> DECODE -> EXEC -> WB over a req/ack instruction port,
// driving an external combinational ALU; supports load-immediate and halt.
module mc_cpu_core #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int REG_N       = 4,
    parameter int INSTR_BYTES = 3
) (
    input  logic              clk,
    input  logic              clr,
    mc_cpu_core_if.master     bus,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z,
    output logic              n,
    output logic              ov,
    output logic              halted
);
    localparam int       IDX_W    = $clog2(REG_N);
    localparam logic [3:0] OP_LOADI = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              req;
    logic [3:0]        op;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs;
    logic [11:0]       imm;
    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] tmp;
    logic              tmp_c;
    logic              tmp_z;
    logic              tmp_n;
    logic              tmp_ov;

    assign bus.imem_addr = pc;
    assign bus.imem_req  = req;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_op    = alu_op;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= S_FETCH;
            pc     <= '0;
            req    <= 1'b0;
            op     <= '0;
            rd     <= '0;
            rs     <= '0;
            imm    <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            tmp    <= '0;
            tmp_c  <= 1'b0;
            tmp_z  <= 1'b0;
            tmp_n  <= 1'b0;
            tmp_ov <= 1'b0;
            result <= '0;
            c      <= 1'b0;
            z      <= 1'b0;
            n      <= 1'b0;
            ov     <= 1'b0;
            halted <= 1'b0;
            // NOTE: the register file is small and must read as zero after clr, so it is
            // reset as flops here rather than inferred as an unreset RAM.
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    // req rises one cycle after entering FETCH from reset, so a stale ack is ignored
                    if (!req) begin
                        req <= 1'b1;
                    end else if (bus.imem_ack) begin
                        op    <= bus.imem_data[23:20];
                        rd    <= bus.imem_data[16 +: IDX_W];
                        rs    <= bus.imem_data[12 +: IDX_W];
                        imm   <= bus.imem_data[11:0];
                        req   <= 1'b0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_a  <= regs[rd];
                    alu_b  <= regs[rs];
                    alu_op <= op;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        if (op == OP_LOADI) begin
                            tmp <= DATA_W'($signed(imm));
                        end else begin
                            tmp    <= bus.alu_f;
                            tmp_c  <= bus.alu_c;
                            tmp_z  <= bus.alu_z;
                            tmp_n  <= bus.alu_n;
                            tmp_ov <= bus.alu_ov;
                        end
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    regs[rd] <= tmp;
                    result   <= tmp;
                    if (op != OP_LOADI) begin
                        c  <= tmp_c;
                        z  <= tmp_z;
                        n  <= tmp_n;
                        ov <= tmp_ov;
                    end
                    pc    <= pc + ADDR_W'(INSTR_BYTES);
                    req   <= 1'b1;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: a memory responder driven from tasks and a
// behavioural 16-bit ALU (op 0 = ADD, op 1 = SUB, others pass A).
module tb_mc_cpu_core;
    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] result;
    logic        c, z, n, ov, halted;
    logic [16:0] alu_wide;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mc_cpu_core_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    mc_cpu_core #(.DATA_W(16), .ADDR_W(8), .REG_N(4), .INSTR_BYTES(3)) dut (
        .clk    (clk),
        .clr    (clr),
        .bus    (bus),
        .result (result),
        .c      (c),
        .z      (z),
        .n      (n),
        .ov     (ov),
        .halted (halted)
    );

    always_comb begin
        alu_wide   = {1'b0, bus.alu_a};
        bus.alu_ov = 1'b0;
        case (bus.alu_op)
            4'h0: alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            4'h1: alu_wide = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
            default: alu_wide = {1'b0, bus.alu_a};
        endcase
        bus.alu_f = alu_wide[15:0];
        bus.alu_c = alu_wide[16];
        bus.alu_z = (alu_wide[15:0] == 16'h0000);
        bus.alu_n = alu_wide[15];
        if (bus.alu_op == 4'h0)
            bus.alu_ov = (bus.alu_a[15] == bus.alu_b[15]) && (alu_wide[15] != bus.alu_a[15]);
        else if (bus.alu_op == 4'h1)
            bus.alu_ov = (bus.alu_a[15] != bus.alu_b[15]) && (alu_wide[15] != bus.alu_a[15]);
    end

    // Wait for a fetch request, hold ack low for w cycles, then present one instruction.
    task automatic fetch_instr(input logic [23:0] instr, input int w, output int cycles, output bit ok);
        int          t;
        logic [7:0]  addr0;
        ok = 1'b1;
        cycles = 0;
        t = 0;
        while (bus.imem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.imem_req !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout: imem_req=%b, required 1", bus.imem_req);
            ok = 1'b0;
            return;
        end
        addr0 = bus.imem_addr;
        for (int i = 0; i < w; i++) begin
            bus.imem_ack  = 1'b0;
            bus.imem_data = instr;
            @(negedge clk);
            cycles++;
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr0) begin
                failures++;
                $display("FAIL wait_hold: req=%b addr=%h, required req=1 addr=%h", bus.imem_req, bus.imem_addr, addr0);
            end
        end
        bus.imem_data = instr;
        bus.imem_ack  = 1'b1;
        @(negedge clk);
        cycles++;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 24'hA5A5A5;
    endtask

    // Fetch an instruction and wait for the core to come back to FETCH with req high.
    task automatic run_instr(input logic [23:0] instr, input int w, output int cycles);
        bit ok;
        int t;
        fetch_instr(instr, w, cycles, ok);
        if (!ok) return;
        t = 0;
        while (bus.imem_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            cycles++;
            t++;
        end
        if (bus.imem_req !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL retire_timeout: imem_req=%b, required 1", bus.imem_req);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 24'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.imem_addr !== 8'h00 || bus.imem_req !== 1'b0 || bus.alu_op !== 4'h0) begin
            failures++;
            $display("FAIL reset_port: addr=%h req=%b alu_op=%h, required 00 0 0", bus.imem_addr, bus.imem_req, bus.alu_op);
        end
        checks++;
        if (result !== 16'h0000 || {c, z, n, ov} !== 4'b0000 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: result=%h flags=%b halted=%b, required 0000 0000 0", result, {c, z, n, ov}, halted);
        end
        // A pending ack at release must not be taken before req rises.
        bus.imem_ack  = 1'b1;
        bus.imem_data = 24'hE1_0123;
        clr = 1'b0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_release: req=%b addr=%h, required 1 00", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_loadi();
        int cyc;
        run_instr(24'hE1_0005, 0, cyc);
        checks++;
        if (result !== 16'h0005 || cyc != 4) begin
            failures++;
            $display("FAIL loadi_r1: result=%h cycles=%0d, required 0005 4", result, cyc);
        end
        run_instr(24'hE2_0FFF, 0, cyc);
        checks++;
        if (result !== 16'hFFFF || {c, z, n, ov} !== 4'b0000 || bus.imem_addr !== 8'h06) begin
            failures++;
            $display("FAIL loadi_r2: result=%h flags=%b pc=%h, required FFFF 0000 06", result, {c, z, n, ov}, bus.imem_addr);
        end
    endtask

    task automatic test_alu();
        int cyc;
        run_instr(24'h01_2000, 0, cyc);  // ADD R1,R2
        checks++;
        if (bus.alu_a !== 16'h0005 || bus.alu_b !== 16'hFFFF) begin
            failures++;
            $display("FAIL add_operands: a=%h b=%h, required 0005 FFFF", bus.alu_a, bus.alu_b);
        end
        checks++;
        if (result !== 16'h0004 || {c, z, n, ov} !== 4'b1000 || bus.imem_addr !== 8'h09) begin
            failures++;
            $display("FAIL add_result: result=%h flags=%b pc=%h, required 0004 1000 09", result, {c, z, n, ov}, bus.imem_addr);
        end
        run_instr(24'hE3_0800, 0, cyc);  // LOADI R3,#0x800 keeps flags
        checks++;
        if (result !== 16'hF800 || {c, z, n, ov} !== 4'b1000) begin
            failures++;
            $display("FAIL loadi_flags_kept: result=%h flags=%b, required F800 1000", result, {c, z, n, ov});
        end
        run_instr(24'h01_1000, 0, cyc);  // ADD R1,R1 with rd==rs
        checks++;
        if (bus.alu_a !== 16'h0004 || bus.alu_b !== 16'h0004 || result !== 16'h0008 || {c, z, n, ov} !== 4'b0000) begin
            failures++;
            $display("FAIL add_same_reg: a=%h b=%h result=%h flags=%b, required 0004 0004 0008 0000",
                     bus.alu_a, bus.alu_b, result, {c, z, n, ov});
        end
        run_instr(24'h02_2000, 0, cyc);  // ADD R2,R2
        checks++;
        if (result !== 16'hFFFE || {c, z, n, ov} !== 4'b1010 || bus.imem_addr !== 8'h12) begin
            failures++;
            $display("FAIL add_negative: result=%h flags=%b pc=%h, required FFFE 1010 12", result, {c, z, n, ov}, bus.imem_addr);
        end
        run_instr(24'h10_0000, 0, cyc);  // SUB R0,R0
        checks++;
        if (result !== 16'h0000 || z !== 1'b1 || n !== 1'b0) begin
            failures++;
            $display("FAIL sub_zero: result=%h z=%b n=%b, required 0000 1 0", result, z, n);
        end
    endtask

    task automatic test_wait_ack();
        int cyc;
        run_instr(24'hE0_0123, 3, cyc);
        checks++;
        if (cyc != 7 || result !== 16'h0123 || bus.imem_addr !== 8'h18 || z !== 1'b1) begin
            failures++;
            $display("FAIL wait_ack: cycles=%0d result=%h pc=%h z=%b, required 7 0123 18 1", cyc, result, bus.imem_addr, z);
        end
    endtask

    task automatic test_clr_mid_exec();
        int cyc;
        bit ok;
        fetch_instr(24'hE1_07FF, 0, cyc, ok);
        @(negedge clk);  // core now in EXEC
        clr = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h00 || result !== 16'h0000 || {c, z, n, ov} !== 4'b0000) begin
            failures++;
            $display("FAIL clr_abort: req=%b addr=%h result=%h flags=%b, required 0 00 0000 0000",
                     bus.imem_req, bus.imem_addr, result, {c, z, n, ov});
        end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || result !== 16'h0000) begin
            failures++;
            $display("FAIL clr_refetch: req=%b addr=%h result=%h, required 1 00 0000", bus.imem_req, bus.imem_addr, result);
        end
    endtask

    task automatic test_pc_wrap();
        int cyc;
        int bad = 0;
        // 3*85 = 0xFF, so the 86th retire wraps to 0x02; 170 retires land on 0xFE.
        for (int i = 0; i < 170; i++) begin
            run_instr(24'hE1_0005, 0, cyc);
            if (cyc != 4) bad++;
            if (i == 85) begin
                checks++;
                if (bus.imem_addr !== 8'h02) begin
                    failures++;
                    $display("FAIL pc_first_wrap: pc=%h, required 02", bus.imem_addr);
                end
            end
        end
        checks++;
        if (bad != 0 || bus.imem_addr !== 8'hFE) begin
            failures++;
            $display("FAIL pc_before_wrap: pc=%h bad_latency=%0d, required FE 0", bus.imem_addr, bad);
        end
        run_instr(24'hE1_0005, 0, cyc);
        checks++;
        if (bus.imem_addr !== 8'h01 || result !== 16'h0005) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h result=%h, required 01 0005", bus.imem_addr, result);
        end
    endtask

    task automatic test_halt();
        int cyc;
        int bad = 0;
        bit ok;
        fetch_instr(24'hF0_0000, 0, cyc, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter: halted=%b req=%b, required 1 0", halted, bus.imem_req);
        end
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack  = i[0];
            bus.imem_data = 24'hE1_0777;
            @(negedge clk);
            if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.imem_addr !== 8'h01 ||
                result !== 16'h0005 || {c, z, n, ov} !== 4'b0000) bad++;
        end
        bus.imem_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_frozen: %0d cycles changed, required 0", bad);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL halt_clr: halted=%b req=%b addr=%h, required 0 1 00", halted, bus.imem_req, bus.imem_addr);
        end
        run_instr(24'hE2_00A0, 0, cyc);
        checks++;
        if (result !== 16'h00A0 || bus.imem_addr !== 8'h03 || cyc != 4) begin
            failures++;
            $display("FAIL halt_restart: result=%h pc=%h cycles=%0d, required 00A0 03 4", result, bus.imem_addr, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_loadi();
        test_alu();
        test_wait_ack();
        test_clr_mid_exec();
        test_pc_wrap();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
